// File: rtl/usb_fs_ep_arb.sv
// USB full-speed endpoint arbiter: round-robin grant with one idle cycle between
// owners, lock-protected hold, and a hold-time limit when others are waiting.

module usb_fs_ep_arb_lane #(
  parameter int DATA_W = 8
) (
  input  logic              grant,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_gated,
  output logic              rival
);
  assign data_gated = grant ? data : '0;
  assign rival      = req & ~grant;
endmodule

module usb_fs_ep_arb #(
  parameter  int NUM_EPS  = 4,
  parameter  int DATA_W   = 8,
  parameter  int MAX_HOLD = 1024,
  localparam int IDX_W    = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_EPS-1:0]        ep_req,
  input  logic [NUM_EPS*DATA_W-1:0] ep_data,
  input  logic                      lock,
  output logic [NUM_EPS-1:0]        ep_grant,
  output logic                      arb_valid,
  output logic [IDX_W-1:0]          arb_idx,
  output logic [DATA_W-1:0]         arb_data,
  output logic                      hold_timeout
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // Counter stops at MAX_HOLD-1 so a late rival still matches the limit.
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '1;
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_EPS - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                           state, state_nxt;
  logic [IDX_W-1:0]                 owner, ptr;
  logic [IDX_W-1:0]                 pick, pick_hi, pick_lo;
  logic                             pick_vld, hi_vld, lo_vld;
  logic [HOLD_W-1:0]                hold_cnt;
  logic                             owner_req, any_rival, force_rel;
  logic [NUM_EPS-1:0][DATA_W-1:0]   data_vec, data_gated;
  logic [NUM_EPS-1:0]               rival_vec;

  assign data_vec = ep_data;

  for (genvar i = 0; i < NUM_EPS; i++) begin : g_lane
    usb_fs_ep_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .grant      (ep_grant[i]),
      .req        (ep_req[i]),
      .data       (data_vec[i]),
      .data_gated (data_gated[i]),
      .rival      (rival_vec[i])
    );
  end

  // Round-robin: lowest requester above ptr, else wrap to the lowest requester.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int i = NUM_EPS - 1; i >= 0; i--) begin
      if (ep_req[i] && (IDX_W'(i) > ptr)) begin
        hi_vld  = 1'b1;
        pick_hi = IDX_W'(i);
      end
      if (ep_req[i]) begin
        lo_vld  = 1'b1;
        pick_lo = IDX_W'(i);
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick     = hi_vld ? pick_hi : pick_lo;
  end

  assign owner_req = |(ep_req & ep_grant);
  assign any_rival = |rival_vec;
  assign force_rel = (MAX_HOLD != 0) && (state == GRANT) && !lock &&
                     (hold_cnt == HOLD_LAST) && any_rival;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= '0;
      ptr          <= PTR_RST;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_timeout <= force_rel;
      if (state == IDLE && pick_vld) begin
        owner    <= pick;
        ptr      <= pick;
        hold_cnt <= '0;
      end else if (state == GRANT && !lock && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pick_vld) state_nxt = GRANT;
      GRANT: if ((!owner_req && !lock) || force_rel) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ep_grant = '0;
    for (int i = 0; i < NUM_EPS; i++)
      ep_grant[i] = (state == GRANT) && (owner == IDX_W'(i));
    arb_valid = (state == GRANT);
    arb_idx   = (state == GRANT) ? owner : '0;
  end

  // Non-owners gate to zero, so the OR is the owner's slice or all zeros.
  always_comb begin
    arb_data = '0;
    for (int i = 0; i < NUM_EPS; i++)
      arb_data = arb_data | data_gated[i];
  end

endmodule
